key_voice_allocator: RTL and testbench

Polyphonic successor to the single-key ASCII-to-note decoder in the electronic-organ datapath. It accepts keyboard press/release events as ASCII codes, maps them to note numbers 1–21 and assigns held notes to `NUM_VOICES` independent voice channels. It keeps per-voice age so new presses can reuse or steal voices deterministically. It sits between the keyboard receiver and the per-voice tone generators.

---
 rtl/key_voice_allocator.sv | 209 ++++++++++++++++++++
 tb/tb_key_voice_allocator.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/key_voice_allocator.sv
// Polyphonic key-to-voice allocator: ASCII press/release events -> notes 1..21 on NUM_VOICES channels.
// Optional build macro VOICE_STEAL_EN: steal the oldest voice when all are busy instead of dropping.
module key_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 5,
    parameter int AGE_W      = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         key_valid_i,
    output logic                         key_ready_o,
    input  logic [7:0]                   key_ascii_i,
    input  logic                         key_release_i,
    input  logic                         all_off_i,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note_o,
    output logic [NUM_VOICES-1:0]        voice_active_o,
    output logic [NUM_VOICES-1:0]        voice_trig_o,
    output logic                         overflow_o
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_COMMIT} state_t;

    state_t                 state_q;
    logic                   ready_q;
    logic [7:0]             ascii_q;
    logic                   release_q;
    logic [NOTE_W-1:0]      note_q [NUM_VOICES];
    logic [AGE_W-1:0]       age_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0]  trig_q;
    logic [NOTE_W-1:0]      evt_note_q;
    logic                   hit_q, free_q;
    logic [IDX_W-1:0]       hit_idx_q, free_idx_q;

    logic [NOTE_W-1:0]      lk_note;
    logic                   lk_hit, lk_free;
    logic [IDX_W-1:0]       lk_hit_idx, lk_free_idx;
    logic                   press_go;
    logic [IDX_W-1:0]       press_idx;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]       old_idx_q, lk_old_idx;
    logic [AGE_W-1:0]       lk_old_age;
`else
    logic                   drop;
    logic                   overflow_q;
`endif

    function automatic logic [4:0] decode(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            8'h51: decode = 5'd1;   8'h57: decode = 5'd2;   8'h45: decode = 5'd3;
            8'h52: decode = 5'd4;   8'h54: decode = 5'd5;   8'h59: decode = 5'd6;
            8'h55: decode = 5'd7;   8'h41: decode = 5'd8;   8'h53: decode = 5'd9;
            8'h44: decode = 5'd10;  8'h46: decode = 5'd11;  8'h47: decode = 5'd12;
            8'h48: decode = 5'd13;  8'h4A: decode = 5'd14;  8'h5A: decode = 5'd15;
            8'h58: decode = 5'd16;  8'h43: decode = 5'd17;  8'h56: decode = 5'd18;
            8'h42: decode = 5'd19;  8'h4E: decode = 5'd20;  8'h4D: decode = 5'd21;
            default: decode = 5'd0;
        endcase
    endfunction

    // Voice table search; note 0 marks a free voice, so an unmapped code never "hits".
    always_comb begin
        lk_note     = NOTE_W'(decode(ascii_q));
        lk_hit      = 1'b0;
        lk_hit_idx  = '0;
        lk_free     = 1'b0;
        lk_free_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!lk_hit && lk_note != '0 && note_q[i] == lk_note) begin
                lk_hit     = 1'b1;
                lk_hit_idx = IDX_W'(i);
            end
            if (!lk_free && note_q[i] == '0) begin
                lk_free     = 1'b1;
                lk_free_idx = IDX_W'(i);
            end
        end
`ifdef VOICE_STEAL_EN
        lk_old_idx = '0;
        lk_old_age = age_q[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age_q[i] > lk_old_age) begin
                lk_old_age = age_q[i];
                lk_old_idx = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        press_go  = 1'b0;
        press_idx = hit_idx_q;
`ifndef VOICE_STEAL_EN
        drop      = 1'b0;
`endif
        if (evt_note_q != '0 && !release_q) begin
            if (hit_q) begin
                press_go = 1'b1;
            end else if (free_q) begin
                press_go  = 1'b1;
                press_idx = free_idx_q;
            end else begin
`ifdef VOICE_STEAL_EN
                press_go  = 1'b1;
                press_idx = old_idx_q;
`else
                drop = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            ascii_q    <= '0;
            release_q  <= 1'b0;
            trig_q     <= '0;
            evt_note_q <= '0;
            hit_q      <= 1'b0;
            free_q     <= 1'b0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
`ifdef VOICE_STEAL_EN
            old_idx_q  <= '0;
`else
            overflow_q <= 1'b0;
`endif
        end else begin
            trig_q <= '0;
`ifndef VOICE_STEAL_EN
            overflow_q <= 1'b0;
`endif
            if (all_off_i) begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    note_q[i] <= '0;
                    age_q[i]  <= '0;
                end
            end else begin
                case (state_q)
                    S_IDLE: if (key_valid_i) begin
                        ascii_q   <= key_ascii_i;
                        release_q <= key_release_i;
                        ready_q   <= 1'b0;
                        state_q   <= S_LOOKUP;
                    end
                    S_LOOKUP: begin
                        evt_note_q <= lk_note;
                        hit_q      <= lk_hit;
                        hit_idx_q  <= lk_hit_idx;
                        free_q     <= lk_free;
                        free_idx_q <= lk_free_idx;
`ifdef VOICE_STEAL_EN
                        old_idx_q  <= lk_old_idx;
`endif
                        state_q    <= S_COMMIT;
                    end
                    S_COMMIT: begin
                        if (press_go) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == press_idx) begin
                                    note_q[i] <= evt_note_q;
                                    age_q[i]  <= '0;
                                    trig_q[i] <= 1'b1;
                                end else if (note_q[i] != '0 && age_q[i] != '1) begin
                                    age_q[i] <= age_q[i] + 1'b1;
                                end
                            end
                        end else if (release_q && hit_q) begin
                            note_q[hit_idx_q] <= '0;
                            age_q[hit_idx_q]  <= '0;
                        end
`ifndef VOICE_STEAL_EN
                        overflow_q <= drop;
`endif
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign voice_note_o[g*NOTE_W +: NOTE_W] = note_q[g];
        assign voice_active_o[g]                = |note_q[g];
    end

    assign key_ready_o  = ready_q;
    assign voice_trig_o = trig_q;
`ifdef VOICE_STEAL_EN
    assign overflow_o = 1'b0;
`else
    assign overflow_o = overflow_q;
`endif
endmodule

// File: tb/tb_key_voice_allocator.sv
// Directed bench for key_voice_allocator (4 voices); expectations follow VOICE_STEAL_EN when defined.
module tb_key_voice_allocator;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        key_valid_i = 1'b0;
    logic        key_ready_o;
    logic [7:0]  key_ascii_i = '0;
    logic        key_release_i = 1'b0;
    logic        all_off_i = 1'b0;
    logic [19:0] voice_note_o;
    logic [3:0]  voice_active_o;
    logic [3:0]  voice_trig_o;
    logic        overflow_o;

    int checks = 0;
    int failures = 0;

    key_voice_allocator #(.NUM_VOICES(4), .NOTE_W(5), .AGE_W(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
        .key_ascii_i(key_ascii_i), .key_release_i(key_release_i), .all_off_i(all_off_i),
        .voice_note_o(voice_note_o), .voice_active_o(voice_active_o),
        .voice_trig_o(voice_trig_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  ascii;
        logic        rel;
        logic [19:0] note;
        logic [3:0]  act;
        logic [3:0]  trig;
        logic        ovf;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [19:0] nv(input int n3, input int n2, input int n1, input int n0);
        return {n3[4:0], n2[4:0], n1[4:0], n0[4:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one event; returns just after the commit edge. Inputs are scrambled after acceptance.
    task automatic send(input logic [7:0] a, input logic r);
        @(negedge clk_i);
        chk("ready_before", 32'(key_ready_o), 32'd1);
        key_valid_i = 1'b1; key_ascii_i = a; key_release_i = r;
        @(posedge clk_i); #1;
        key_valid_i = 1'b0; key_ascii_i = 8'h4D; key_release_i = ~r;
        chk("ready_lookup", 32'(key_ready_o), 32'd0);
        @(posedge clk_i); #1;
        chk("ready_commit", 32'(key_ready_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_note"}, 32'(voice_note_o), 32'd0);
        chk({tag, "_act"}, 32'(voice_active_o), 32'd0);
        chk({tag, "_trig"}, 32'(voice_trig_o), 32'd0);
        chk({tag, "_ready"}, 32'(key_ready_o), 32'd1);
    endtask

    initial begin
`ifdef VOICE_STEAL_EN
        localparam logic STEAL = 1'b1;
`else
        localparam logic STEAL = 1'b0;
`endif
        vecs[0]  = '{8'h51, 1'b0, nv(0,0,0,1),   4'b0001, 4'b0001, 1'b0};
        vecs[1]  = '{8'h51, 1'b1, nv(0,0,0,0),   4'b0000, 4'b0000, 1'b0};
        vecs[2]  = '{8'h77, 1'b0, nv(0,0,0,2),   4'b0001, 4'b0001, 1'b0};
        vecs[3]  = '{8'h45, 1'b0, nv(0,0,3,2),   4'b0011, 4'b0010, 1'b0};
        vecs[4]  = '{8'h77, 1'b1, nv(0,0,3,0),   4'b0010, 4'b0000, 1'b0};
        vecs[5]  = '{8'h52, 1'b0, nv(0,0,3,4),   4'b0011, 4'b0001, 1'b0};
        vecs[6]  = '{8'h52, 1'b0, nv(0,0,3,4),   4'b0011, 4'b0001, 1'b0};
        vecs[7]  = '{8'h31, 1'b0, nv(0,0,3,4),   4'b0011, 4'b0000, 1'b0};
        vecs[8]  = '{8'h6D, 1'b1, nv(0,0,3,4),   4'b0011, 4'b0000, 1'b0};
        vecs[9]  = '{8'h5A, 1'b0, nv(0,15,3,4),  4'b0111, 4'b0100, 1'b0};
        vecs[10] = '{8'h6A, 1'b0, nv(14,15,3,4), 4'b1111, 4'b1000, 1'b0};
        if (STEAL) begin
            // ages before T: v0=2 v1=5 v2=1 v3=0 -> v1 stolen; then v0 (age 3) is oldest
            vecs[11] = '{8'h54, 1'b0, nv(14,15,5,4),   4'b1111, 4'b0010, 1'b0};
            vecs[12] = '{8'h58, 1'b0, nv(14,15,5,16),  4'b1111, 4'b0001, 1'b0};
            vecs[13] = '{8'h5A, 1'b1, nv(14,0,5,16),   4'b1011, 4'b0000, 1'b0};
            vecs[14] = '{8'h62, 1'b0, nv(14,19,5,16),  4'b1111, 4'b0100, 1'b0};
        end else begin
            vecs[11] = '{8'h54, 1'b0, nv(14,15,3,4),   4'b1111, 4'b0000, 1'b1};
            vecs[12] = '{8'h58, 1'b0, nv(14,15,3,4),   4'b1111, 4'b0000, 1'b1};
            vecs[13] = '{8'h5A, 1'b1, nv(14,0,3,4),    4'b1011, 4'b0000, 1'b0};
            vecs[14] = '{8'h62, 1'b0, nv(14,19,3,4),   4'b1111, 4'b0100, 1'b0};
        end

        #12;
        chk_clear("reset");
        chk("reset_ovf", 32'(overflow_o), 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;

        for (int i = 0; i < 15; i++) begin
            send(vecs[i].ascii, vecs[i].rel);
            chk($sformatf("v%0d_note", i), 32'(voice_note_o), 32'(vecs[i].note));
            chk($sformatf("v%0d_act", i), 32'(voice_active_o), 32'(vecs[i].act));
            chk($sformatf("v%0d_trig", i), 32'(voice_trig_o), 32'(vecs[i].trig));
            chk($sformatf("v%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].ovf));
            @(posedge clk_i); #1;
            chk($sformatf("v%0d_trig_end", i), 32'(voice_trig_o), 32'd0);
            chk($sformatf("v%0d_ovf_end", i), 32'(overflow_o), 32'd0);
            chk($sformatf("v%0d_note_hold", i), 32'(voice_note_o), 32'(vecs[i].note));
        end

        // all_off asserted while the press of 'Y' sits in COMMIT
        @(negedge clk_i);
        key_valid_i = 1'b1; key_ascii_i = 8'h59; key_release_i = 1'b0;
        @(posedge clk_i); #1 key_valid_i = 1'b0;
        @(posedge clk_i); #1 all_off_i = 1'b1;
        @(posedge clk_i); #1;
        chk_clear("alloff");
        chk("alloff_ovf", 32'(overflow_o), 32'd0);
        all_off_i = 1'b0;
        send(8'h51, 1'b0);
        chk("alloff_after_note", 32'(voice_note_o), 32'(nv(0,0,0,1)));
        chk("alloff_after_trig", 32'(voice_trig_o), 32'h1);

        // reset asserted while the press of 'T' sits in LOOKUP
        send(8'h57, 1'b0);
        send(8'h45, 1'b0);
        chk("three_held", 32'(voice_active_o), 32'h7);
        @(negedge clk_i);
        key_valid_i = 1'b1; key_ascii_i = 8'h54; key_release_i = 1'b0;
        @(posedge clk_i); #1 key_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk_clear("midrst");
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk_clear("midrst_idle");
        send(8'h74, 1'b0);
        chk("midrst_after_note", 32'(voice_note_o), 32'(nv(0,0,0,5)));
        chk("midrst_after_act", 32'(voice_active_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
